// File: rtl/bcd_7seg_scan.sv
// Multiplexed BCD to seven-segment scanner with a frame-synchronous, tear-free
// input handshake. Define BCD_SCAN_LZB_EN to enable leading-zero blanking.
module bcd_7seg_scan #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned BLANK  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BW = 4 * DIGITS;

    logic [DW-1:0]     div;
    logic [IW-1:0]     idx;
    logic [BW-1:0]     pend;
    logic [BW-1:0]     disp;
    logic              slot_end;
    logic              frame_end;
    logic              accept;
    logic [DIGITS-1:0] lz_blank;
    logic [3:0]        cur_digit;
    logic              cur_lz;
    logic [DIGITS-1:0] an_c;
    logic [6:0]        seg_c;

    assign slot_end  = (div == DW'(DIV - 1));
    assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
    assign accept    = in_valid && in_ready;

    // Slot divider and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
        end else if (slot_end) begin
            div <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            div <= div + DW'(1);
        end
    end

    // Capture into pend; disp only moves on a frame boundary, and only for a
    // capture made on an earlier cycle (in_ready already low).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            disp     <= '0;
            in_ready <= 1'b1;
        end else if (accept) begin
            pend     <= bcd_in;
            in_ready <= 1'b0;
        end else if (!in_ready && frame_end) begin
            disp     <= pend;
            in_ready <= 1'b1;
        end
    end

    // Digit k>0 is a leading zero when it and every digit above it are zero
    always_comb begin
        lz_blank = '0;
`ifdef BCD_SCAN_LZB_EN
        for (int k = 1; k < DIGITS; k++) begin
            lz_blank[k] = ((disp >> (4 * k)) == BW'(0));
        end
`endif
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_lz    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_digit = disp[4*k +: 4];
                cur_lz    = lz_blank[k];
            end
        end
    end

    // Guard interval at slot start keeps all digits dark to avoid ghosting
    always_comb begin
        an_c  = '1;
        seg_c = 7'h7F;
        if (div >= DW'(BLANK)) begin
            an_c = ~(DIGITS'(1) << idx);
            if (!cur_lz) begin
                case (cur_digit)
                    4'd0:    seg_c = 7'h40;
                    4'd1:    seg_c = 7'h79;
                    4'd2:    seg_c = 7'h24;
                    4'd3:    seg_c = 7'h30;
                    4'd4:    seg_c = 7'h19;
                    4'd5:    seg_c = 7'h12;
                    4'd6:    seg_c = 7'h02;
                    4'd7:    seg_c = 7'h78;
                    4'd8:    seg_c = 7'h00;
                    4'd9:    seg_c = 7'h10;
                    default: seg_c = 7'h3F;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'h7F;
        end else begin
            an  <= an_c;
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboard bench for bcd_7seg_scan (DIGITS=4, DIV=8, BLANK=2): expected
// an/seg per cycle are queued per frame and popped as the DUT scans.
module tb_bcd_7seg_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] bcd_in = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  an;
    logic [6:0]  seg;

    int          n_cmp = 0;
    int          n_err = 0;
    int          edges;
    logic [10:0] sb[$];

    bcd_7seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk      (clk),
        .reset    (reset),
        .bcd_in   (bcd_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    // Edges since reset release; output after edge e reflects scan time e-1
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [10:0] exp_out(input int t, input logic [15:0] v);
        int dv;
        int ix;
        logic [3:0] a;
        logic [6:0] s;
        dv = t % DIV;
        ix = (t / DIV) % DIGITS;
        if (dv < BLANK) return {4'hF, 7'h7F};
        a = ~(4'b0001 << ix);
        s = dec(v[ix*4 +: 4]);
`ifdef BCD_SCAN_LZB_EN
        if (ix > 0 && (v >> (ix*4)) == 16'h0) s = 7'h7F;
`endif
        return {a, s};
    endfunction

    task automatic wait_phase(input int ph, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 2*FRAME && !found; i++) begin
            @(posedge clk); #1;
            if (edges % FRAME == ph) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL %s: phase %0d not reached within %0d cycles", name, ph, 2*FRAME);
        end
    endtask

    // Called just after a frame boundary edge: queue a frame, then compare it
    task automatic check_frame(input logic [15:0] v, input logic rdy, input string name);
        logic [10:0] e;
        n_cmp++;
        if (in_ready !== rdy) begin
            n_err++;
            $display("FAIL %s_ready: in_ready=%b expected %b", name, in_ready, rdy);
        end
        for (int j = 0; j < FRAME; j++) sb.push_back(exp_out(edges + j, v));
        for (int j = 0; j < FRAME; j++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++;
            if ({an, seg} !== e) begin
                n_err++;
                $display("FAIL %s cyc=%0d: an=%h seg=%h expected an=%h seg=%h",
                         name, j, an, seg, e[10:7], e[6:0]);
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] e;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_hold: an=%h seg=%h rdy=%b expected F 7F 1", an, seg, in_ready);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                repeat (10) @(posedge clk);
                #1;
                e = exp_out(edges - 1, 16'h0);
                n_cmp++;
                if ({an, seg} !== e) begin
                    n_err++;
                    $display("FAIL pre_rst: an=%h seg=%h expected an=%h seg=%h", an, seg, e[10:7], e[6:0]);
                end
                #2 reset = 1'b1;
                #1;
                n_cmp++;
                if (an !== 4'hF || seg !== 7'h7F || in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL rst_async: an=%h seg=%h rdy=%b expected F 7F 1", an, seg, in_ready);
                end
                @(posedge clk); #1;
                n_cmp++;
                if (an !== 4'hF || seg !== 7'h7F) begin
                    n_err++;
                    $display("FAIL rst_clocked: an=%h seg=%h expected F 7F", an, seg);
                end
            end
            @(negedge clk) reset = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(posedge clk); #1;
                e = exp_out(edges - 1, 16'h0);
                n_cmp++;
                if (an !== ((k == 3) ? 4'hE : 4'hF) || {an, seg} !== e) begin
                    n_err++;
                    $display("FAIL rst_release%0d edge%0d: an=%h seg=%h expected an=%h seg=%h",
                             pass, k, an, seg, e[10:7], e[6:0]);
                end
            end
        end
    endtask

    task automatic test_load_and_ignore();
        bcd_in = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk); #1;
        bcd_in = 16'h5678;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL load_ready_fall: in_ready=%b expected 0", in_ready);
        end
        for (int i = 0; i < FRAME && (edges % FRAME) != FRAME - 1; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ignore_ready: in_ready=%b expected 0", in_ready);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_frame(16'h1234, 1'b1, "load_1234");
    endtask

    task automatic test_invalid_bcd();
        bcd_in = 16'h00A7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL a7_ready: in_ready=%b expected 0", in_ready);
        end
        wait_phase(0, "a7_wait");
        check_frame(16'h00A7, 1'b1, "dash_00A7");
    endtask

    task automatic test_boundary_capture();
        wait_phase(FRAME - 1, "bnd_wait");
        bcd_in = 16'h0089;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bnd_capture: in_ready=%b expected 0", in_ready);
        end
        check_frame(16'h00A7, 1'b0, "bnd_hold");
        check_frame(16'h0089, 1'b1, "bnd_update");
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [3];
        vals[0] = 16'h9000;
        vals[1] = 16'h0305;
        vals[2] = 16'hF1C0;
        for (int i = 0; i < 3; i++) begin
            bcd_in = vals[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            wait_phase(0, "b2b_wait");
            check_frame(vals[i], 1'b1, "b2b");
        end
    endtask

    task automatic test_reset_mid_handshake();
        bcd_in = 16'h4321;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || an !== 4'hF || seg !== 7'h7F) begin
            n_err++;
            $display("FAIL mid_rst: rdy=%b an=%h seg=%h expected 1 F 7F", in_ready, an, seg);
        end
        @(negedge clk) reset = 1'b0;
        check_frame(16'h0000, 1'b1, "rst_discard");
    endtask

    initial begin
        test_reset();
        test_load_and_ignore();
        test_invalid_bcd();
        test_boundary_capture();
        test_back_to_back();
        test_reset_mid_handshake();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
